ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer for the Simple Computer's single-port data memory.
- Requester A is the CPU load/store unit. Requester B is the I/O/debug loader.
- Each access is latched, presented to the RAM for exactly one cycle, and the read result is captured and returned with a one-cycle ack pulse.
- Sits between the requesters and the single-port data RAM; the RAM's read path is combinational (new data on write).

Parameters:
- ADDR_WIDTH, 6, RAM address width; must match the RAM instance.
- DATA_WIDTH, 8, RAM data width; must match the RAM instance.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- a_req  in  1  requester A access request; level, held until a_ack.
- a_we  in  1  requester A write enable (1 = write, 0 = read).
- a_addr  in  ADDR_WIDTH  requester A address.
- a_wdata  in  DATA_WIDTH  requester A write data.
- a_ack  out  1  one-cycle pulse: A access complete.
- a_rdata  out  DATA_WIDTH  A read data (write: RAM q after write); valid while a_ack=1, then held.
- b_req, b_we, b_addr, b_wdata  in  as for A  requester B request fields.
- b_ack, b_rdata  out  as for A  requester B response.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_q  in  DATA_WIDTH  RAM combinational read data.
- busy  out  1  high in ACCESS or DONE.

Behaviour:
- Reset (resetn=0, async): state=IDLE; a_ack, b_ack, mem_we, busy = 0; mem_addr, mem_data, a_rdata, b_rdata = 0; last_grant = B, so A wins the first tie.
- Reset mid-access: mem_we drops immediately. An access whose write edge has not yet occurred is not committed, and no ack is issued.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is high at the rising edge, latch the winner's we/addr/wdata into mem_we/mem_addr/mem_data and go to ACCESS.
  - Winner set into a one-bit grant register.
  - Otherwise stay in IDLE with mem_we=0.
- Arbitration:
  - Only one requester high: that one wins.
  - Both high: the requester not in last_grant wins; last_grant updates to the winner.
  - The loser's req stays pending with no side effects.
- ACCESS:
  - Exactly one cycle. RAM sees the latched address; write commits at the edge ending this cycle.
  - At that edge: capture mem_q into the granted requester's rdata, assert its ack, drop mem_we, go to DONE.
  - Read data is the RAM value at mem_addr during ACCESS.
- DONE:
  - Granted ack is high for exactly this cycle; go to IDLE.
  - Requests are not sampled in DONE. A requester must drop req in its ack cycle; a req still high when IDLE is sampled is treated as a new access.
- Latency and throughput:
  - req sampled at edge N -> ack high in cycle after edge N+1 (2 cycles) -> IDLE after edge N+2.
  - Maximum one access per 3 cycles.
- Other rules:
  - mem_we is high only in ACCESS and only for a write.
  - mem_addr/mem_data hold their last value outside ACCESS.
  - Request inputs may change freely while not granted; only values at the IDLE sampling edge matter.
  - a_ack and b_ack are never high together. a_rdata/b_rdata change only on their own ack.
  - All outputs are registered; no combinational path from req to mem_* or ack.

Test Plan:
- Reset: hold resetn=0 3 cycles with a_req=1 -> all outputs 0, no mem_we. Release -> A serviced, a_ack 2 cycles after the first sampling edge.
- A writes 0x5A to addr 0x10, then reads 0x10 -> mem_we=1 exactly one cycle with mem_addr=0x10, mem_data=0x5A; read a_rdata=0x5A with a_ack.
- A and B request together (A read 0x01, B write 0x33 to 0x02), held through acks:
  - Grant order A, B.
  - A second simultaneous pair yields B before A.
  - Acks never overlap; spacing is 3 cycles.
- B holds b_req high continuously through its ack -> serviced back-to-back every 3 cycles. a_req raised mid-stream -> A is served next (round-robin), not starved.
- Read-after-write by different requesters: B writes 0xC3 to 0x3F; A reads 0x3F immediately after -> a_rdata=0xC3; address wrap at 0x3F is handled.
- resetn pulsed low during ACCESS of B write 0x77 to 0x05 (old value 0x00) -> mem_we drops immediately, no b_ack. A later read of 0x05 returns 0x00.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Request/response and RAM-side signals of the data-memory arbiter.
// The arbiter connects through the slave modport; the requesters and RAM connect through master.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_ack;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_ack;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_q,
        output a_ack, a_rdata, b_ack, b_rdata,
        output mem_we, mem_addr, mem_data, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_q,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  mem_we, mem_addr, mem_data, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin sequencer for the single-port data RAM.
// Each access runs IDLE -> ACCESS -> DONE; the RAM sees exactly one cycle per access.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic            clock,
    input  logic            resetn,
    ram_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    state_t state;
    state_t state_next;

    logic                  grant;
    logic                  last_grant;
    logic                  any_req;
    logic                  win_b;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // On a tie the requester that did not win the previous tie goes first.
    always_comb begin
        any_req   = bus.a_req | bus.b_req;
        win_b     = bus.b_req & (~bus.a_req | (last_grant == GRANT_A));
        win_we    = win_b ? bus.b_we    : bus.a_we;
        win_addr  = win_b ? bus.b_addr  : bus.a_addr;
        win_wdata = win_b ? bus.b_wdata : bus.a_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: state_next is given a default before the case so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grant        <= GRANT_A;
            last_grant   <= GRANT_B;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            bus.a_ack    <= 1'b0;
            bus.b_ack    <= 1'b0;
            bus.a_rdata  <= '0;
            bus.b_rdata  <= '0;
            bus.busy     <= 1'b0;
        end else begin
            bus.a_ack <= 1'b0;
            bus.b_ack <= 1'b0;
            bus.busy  <= (state_next != IDLE);
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.mem_we   <= win_we;
                        bus.mem_addr <= win_addr;
                        bus.mem_data <= win_wdata;
                        grant        <= win_b;
                        if (bus.a_req && bus.b_req) last_grant <= win_b;
                    end
                end
                ACCESS: begin
                    // mem_q is write-through, so a write returns the stored value.
                    bus.mem_we <= 1'b0;
                    if (grant == GRANT_B) begin
                        bus.b_rdata <= bus.mem_q;
                        bus.b_ack   <= 1'b1;
                    end else begin
                        bus.a_rdata <= bus.mem_q;
                        bus.a_ack   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table-driven single accesses plus hand-written
// sequences for reset, simultaneous requests, streaming and reset mid-access.
module tb_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;

    logic clock;
    logic resetn;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // Single-port RAM model: combinational read, new data visible while writing.
    logic [DW-1:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = '0;
    always @(posedge clock) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
    assign bus.mem_q = bus.mem_we ? bus.mem_data : ram[bus.mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (resetn && bus.a_ack && bus.b_ack) begin
            n_fail++;
            $display("FAIL ack_overlap: a_ack=1 b_ack=1 at cycle %0d, required at most one", cyc);
        end
    end

    typedef struct {
        logic          a_req;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        logic          b_req;
        logic          b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
        logic          exp_b;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    // Waits for one ack pulse; returns its cycle number or -1 on timeout.
    task automatic wait_ack(input bit is_b, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            if (is_b ? bus.b_ack : bus.a_ack) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s_ack_timeout: got none in %0d cycles, required a pulse", is_b ? "b" : "a", budget);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        e_we   = v.exp_b ? v.b_we    : v.a_we;
        e_addr = v.exp_b ? v.b_addr  : v.a_addr;
        e_data = v.exp_b ? v.b_wdata : v.a_wdata;
        n_vec++;
        @(negedge clock);
        bus.a_req = v.a_req; bus.a_we = v.a_we; bus.a_addr = v.a_addr; bus.a_wdata = v.a_wdata;
        bus.b_req = v.b_req; bus.b_we = v.b_we; bus.b_addr = v.b_addr; bus.b_wdata = v.b_wdata;
        @(posedge clock); #1;
        check($sformatf("v%0d_access_busy", idx), 32'(bus.busy), 32'd1);
        check($sformatf("v%0d_access_mem_we", idx), 32'(bus.mem_we), 32'(e_we));
        check($sformatf("v%0d_access_mem_addr", idx), 32'(bus.mem_addr), 32'(e_addr));
        check($sformatf("v%0d_access_mem_data", idx), 32'(bus.mem_data), 32'(e_data));
        check($sformatf("v%0d_access_no_ack", idx), 32'({bus.a_ack, bus.b_ack}), 32'd0);
        @(posedge clock); #1;
        check($sformatf("v%0d_done_acks", idx), 32'({bus.a_ack, bus.b_ack}), v.exp_b ? 32'd1 : 32'd2);
        check($sformatf("v%0d_done_rdata", idx),
              32'(v.exp_b ? bus.b_rdata : bus.a_rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d_done_mem_we", idx), 32'(bus.mem_we), 32'd0);
        @(negedge clock);
        idle_inputs();
        @(posedge clock); #1;
        check($sformatf("v%0d_idle_acks", idx), 32'({bus.a_ack, bus.b_ack}), 32'd0);
        check($sformatf("v%0d_idle_busy", idx), 32'(bus.busy), 32'd0);
    endtask

    // Both requesters raise together and hold req until their own ack.
    task automatic run_pair(input bit exp_first_b,
                            input logic a_we, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_wdata,
                            input logic b_we, input logic [AW-1:0] b_addr, input logic [DW-1:0] b_wdata,
                            input logic [DW-1:0] exp_a_rd, input logic [DW-1:0] exp_b_rd, input string name);
        int ta = -1;
        int tb = -1;
        n_vec++;
        @(negedge clock);
        bus.a_req = 1; bus.a_we = a_we; bus.a_addr = a_addr; bus.a_wdata = a_wdata;
        bus.b_req = 1; bus.b_we = b_we; bus.b_addr = b_addr; bus.b_wdata = b_wdata;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (bus.a_ack && ta < 0) begin
                ta = cyc;
                check({name, "_a_rdata"}, 32'(bus.a_rdata), 32'(exp_a_rd));
            end
            if (bus.b_ack && tb < 0) begin
                tb = cyc;
                check({name, "_b_rdata"}, 32'(bus.b_rdata), 32'(exp_b_rd));
            end
            @(negedge clock);
            if (ta >= 0) bus.a_req = 0;
            if (tb >= 0) bus.b_req = 0;
            if (ta >= 0 && tb >= 0) break;
        end
        check({name, "_both_acked"}, 32'({ta >= 0, tb >= 0}), 32'd3);
        check({name, "_b_first"}, 32'(tb < ta), 32'(exp_first_b));
        check({name, "_ack_spacing"}, 32'(exp_first_b ? ta - tb : tb - ta), 32'd3);
        idle_inputs();
        @(posedge clock); #1;
        check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    vec_t vecs[6];
    vec_t post_reset_vec;

    initial begin
        int t0, t1, t2, ta;

        //           a_req a_we a_addr  a_wdata b_req b_we b_addr  b_wdata exp_b rdata
        vecs[0] = '{1'b1, 1'b1, 6'h10, 8'h5A, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 8'h5A};
        vecs[1] = '{1'b1, 1'b0, 6'h10, 8'hFF, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 8'h5A};
        vecs[2] = '{1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b1, 6'h3F, 8'hC3, 1'b1, 8'hC3};
        vecs[3] = '{1'b1, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 8'hC3};
        vecs[4] = '{1'b1, 1'b1, 6'h00, 8'h11, 1'b0, 1'b1, 6'h20, 8'hEE, 1'b0, 8'h11};
        vecs[5] = '{1'b0, 1'b1, 6'h01, 8'h99, 1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 8'h11};
        post_reset_vec = '{1'b1, 1'b0, 6'h05, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 8'h00};

        // Reset held with A requesting: nothing moves.
        idle_inputs();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 6'h00;
        n_vec++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("rst_mem_we", 32'(bus.mem_we), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_acks", 32'({bus.a_ack, bus.b_ack}), 32'd0);
            check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            check("rst_mem_data", 32'(bus.mem_data), 32'd0);
            check("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'd0);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        t0 = cyc;
        check("rst_release_busy", 32'(bus.busy), 32'd1);
        check("rst_release_no_ack", 32'(bus.a_ack), 32'd0);
        wait_ack(1'b0, 4, ta);
        check("rst_release_ack_latency", 32'(ta - t0), 32'd1);
        @(negedge clock);
        idle_inputs();
        @(posedge clock); #1;
        check("rst_release_ack_pulse", 32'(bus.a_ack), 32'd0);

        for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

        run_pair(1'b0, 1'b0, 6'h01, 8'h00, 1'b1, 6'h02, 8'h33, 8'h00, 8'h33, "pair1");
        run_pair(1'b1, 1'b1, 6'h01, 8'h44, 1'b0, 6'h02, 8'h00, 8'h44, 8'h33, "pair2");

        // B streams reads; A joins and is served before B's next access.
        n_vec++;
        @(negedge clock);
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 6'h3F;
        wait_ack(1'b1, 6, t0);
        check("stream_b_rdata", 32'(bus.b_rdata), 32'hC3);
        wait_ack(1'b1, 6, t1);
        check("stream_b_spacing", 32'(t1 - t0), 32'd3);
        @(negedge clock);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 6'h10;
        wait_ack(1'b0, 6, ta);
        check("stream_a_next", 32'(ta - t1), 32'd3);
        check("stream_a_rdata", 32'(bus.a_rdata), 32'h5A);
        @(negedge clock);
        bus.a_req = 0;
        wait_ack(1'b1, 6, t2);
        check("stream_b_resume", 32'(t2 - ta), 32'd3);
        @(negedge clock);
        idle_inputs();
        @(posedge clock); #1;
        check("stream_idle_busy", 32'(bus.busy), 32'd0);

        // Reset pulsed during B's write ACCESS cycle.
        n_vec++;
        @(negedge clock);
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 6'h05; bus.b_wdata = 8'h77;
        @(posedge clock); #1;
        check("midrst_access_we", 32'(bus.mem_we), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_we_drop", 32'(bus.mem_we), 32'd0);
        check("midrst_busy_drop", 32'(bus.busy), 32'd0);
        idle_inputs();
        @(posedge clock); #1;
        check("midrst_no_b_ack", 32'(bus.b_ack), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        check("midrst_no_late_ack", 32'({bus.a_ack, bus.b_ack}), 32'd0);
        apply_vec(post_reset_vec, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
